// File: rtl/fpu_test_pkg.sv
// rtl/fpu_test_pkg.sv - shared widths and FSM state type for the FPU test sequencer
//
// Purpose: common localparams and the sequencer state enum.
// Ports:   none (package).
package fpu_test_pkg;

  localparam int OP_W   = 2;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - in-order tag FIFO holding addresses of in-flight FPU requests
//
// Purpose: synchronous push/pop FIFO with show-ahead read data and async reset.
// Ports:
//   clock, reset       - clock and asynchronous active-high reset
//   push, push_data    - write a tag (ignored when full)
//   pop                - drop the head tag (ignored when empty)
//   pop_data           - head tag, valid whenever empty is low
//   empty, count       - occupancy status
module tag_fifo
  import fpu_test_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ADDR_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (cnt != FULL_CNT);
  assign do_pop   = pop && (cnt != '0);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fpu_test_seq.sv
// rtl/fpu_test_seq.sv - walks an operand memory, issues FPU requests and tags results
//
// Purpose: issues one FPU request per operand-memory entry 0..cfg_last, keeps at
//          most MAX_OUTST in flight, and re-tags in-order responses with their
//          source address while accumulating a 16-bit checksum.
// Ports:
//   clock, reset                  - clock and asynchronous active-high reset
//   start, cfg_last               - run launch pulse and last address of the run
//   mem_addr, mem_op/opA/opB      - operand memory port (combinational read)
//   fpu_req_valid/ready, fpu_op/opA/opB - request handshake and payload
//   fpu_rsp_valid, fpu_rsp_data   - in-order responses, no backpressure
//   res_valid, res_addr, res_data - tagged result stream
//   busy, done, err, checksum     - run status, sticky protocol error, result sum
module fpu_test_seq
  import fpu_test_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_last,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [OP_W-1:0]   mem_op,
  input  logic [DATA_W-1:0] mem_opA,
  input  logic [DATA_W-1:0] mem_opB,
  output logic              fpu_req_valid,
  input  logic              fpu_req_ready,
  output logic [OP_W-1:0]   fpu_op,
  output logic [DATA_W-1:0] fpu_opA,
  output logic [DATA_W-1:0] fpu_opB,
  input  logic              fpu_rsp_valid,
  input  logic [DATA_W-1:0] fpu_rsp_data,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] issue_ptr;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] tag_head;
  logic [CW-1:0]     outstanding;
  logic              tags_empty;
  logic              start_ok;
  logic              accept;
  logic              rsp_pop;
  logic              rsp_spur;

  // Payload is the memory read at issue_ptr; issue_ptr only moves on acceptance,
  // so a pending request holds its payload while the FPU stalls.
  assign mem_addr = issue_ptr;
  assign fpu_op   = mem_op;
  assign fpu_opA  = mem_opA;
  assign fpu_opB  = mem_opB;

  assign start_ok      = start && ((state == IDLE) || (state == DONE));
  // Once raised, valid stays up: outstanding cannot grow without an acceptance.
  assign fpu_req_valid = (state == ISSUE) && (outstanding < MAX_CNT);
  assign accept        = fpu_req_valid && fpu_req_ready;
  assign rsp_pop       = fpu_rsp_valid && !tags_empty;
  assign rsp_spur      = fpu_rsp_valid && tags_empty;

  tag_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (ADDR_W)
  ) u_tags (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (issue_ptr),
    .pop       (rsp_pop),
    .pop_data  (tag_head),
    .empty     (tags_empty),
    .count     (outstanding)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (accept && (issue_ptr == last_q)) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // A response in flight this cycle still has to be retired first.
        if ((outstanding == '0) && !fpu_rsp_valid) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = ISSUE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_ptr <= '0;
      last_q    <= '0;
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
      checksum  <= '0;
      err       <= 1'b0;
    end else begin
      if (start_ok) begin
        issue_ptr <= '0;
        last_q    <= cfg_last;
      end else if (accept) begin
        issue_ptr <= issue_ptr + ADDR_W'(1);
      end

      res_valid <= rsp_pop;
      if (rsp_pop) begin
        res_addr <= tag_head;
        res_data <= fpu_rsp_data;
      end

      if (start_ok) begin
        checksum <= '0;
      end else if (rsp_pop) begin
        checksum <= checksum + fpu_rsp_data;
      end

      if (start_ok) begin
        err <= 1'b0;
      end else if (rsp_spur) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_test_seq.sv
// tb/tb_fpu_test_seq.sv - self-checking bench for fpu_test_seq with an FPU model
module tb_fpu_test_seq;
  import fpu_test_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  cfg_last;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_op;
  logic [15:0] mem_opA;
  logic [15:0] mem_opB;
  logic        fpu_req_valid;
  logic        fpu_req_ready;
  logic [1:0]  fpu_op;
  logic [15:0] fpu_opA;
  logic [15:0] fpu_opB;
  logic        fpu_rsp_valid;
  logic [15:0] fpu_rsp_data;
  logic        res_valid;
  logic [7:0]  res_addr;
  logic [15:0] res_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] checksum;

  fpu_test_seq #(.MAX_OUTST(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .cfg_last      (cfg_last),
    .mem_addr      (mem_addr),
    .mem_op        (mem_op),
    .mem_opA       (mem_opA),
    .mem_opB       (mem_opB),
    .fpu_req_valid (fpu_req_valid),
    .fpu_req_ready (fpu_req_ready),
    .fpu_op        (fpu_op),
    .fpu_opA       (fpu_opA),
    .fpu_opB       (fpu_opB),
    .fpu_rsp_valid (fpu_rsp_valid),
    .fpu_rsp_data  (fpu_rsp_data),
    .res_valid     (res_valid),
    .res_addr      (res_addr),
    .res_data      (res_data),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .checksum      (checksum)
  );

  always #5 clock = ~clock;

  // Operand memory with combinational read.
  logic [1:0]  m_op [256];
  logic [15:0] m_a  [256];
  logic [15:0] m_b  [256];
  assign mem_op  = m_op[mem_addr];
  assign mem_opA = m_a[mem_addr];
  assign mem_opB = m_b[mem_addr];

  function automatic logic [15:0] fpu_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // FPU model: in-order pipeline with programmable latency and a hold switch.
  typedef struct { logic [15:0] data; int due; } pend_t;
  pend_t       pend [$];
  int          cyc = 0;
  int          lat = 2;
  int          accept_cnt = 0;
  int          release_n = 0;
  bit          auto_rsp = 1'b1;
  logic        model_v = 1'b0;
  logic        spur = 1'b0;
  logic [15:0] model_d = '0;
  int          acc_addr [$];
  int          acc_cyc [$];
  int          got_addr [$];
  logic [15:0] got_data [$];

  assign fpu_rsp_valid = model_v | spur;
  assign fpu_rsp_data  = model_d;

  always @(posedge clock) begin
    pend_t p;
    if (fpu_req_valid && fpu_req_ready) begin
      accept_cnt++;
      acc_addr.push_back(int'(mem_addr));
      acc_cyc.push_back(cyc);
      p.data = fpu_fn(fpu_op, fpu_opA, fpu_opB);
      p.due  = cyc + lat;
      pend.push_back(p);
    end
    if (res_valid) begin
      got_addr.push_back(int'(res_addr));
      got_data.push_back(res_data);
    end
    cyc++;
  end

  always @(negedge clock) begin
    model_v = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc && (auto_rsp || release_n > 0)) begin
      model_v = 1'b1;
      model_d = pend[0].data;
      pend.delete(0);
      if (!auto_rsp) release_n--;
    end
  end

  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_valid"}, 32'(fpu_req_valid), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_addr"},  32'(res_addr), 0);
    chk({tag, "_res_data"},  32'(res_data), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_done"},      32'(done), 0);
    chk({tag, "_err"},       32'(err), 0);
    chk({tag, "_checksum"},  32'(checksum), 0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 0);
  endtask

  task automatic start_run(input int last);
    acc_addr.delete();
    acc_cyc.delete();
    got_addr.delete();
    got_data.delete();
    @(negedge clock);
    cfg_last = 8'(last);
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit rand_rdy, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clock);
      if (rand_rdy) fpu_req_ready = 1'($urandom_range(0, 1));
      n++;
    end
    fpu_req_ready = 1'b1;
    chk({tag, "_done_within_budget"}, 32'(done), 1);
  endtask

  task automatic check_results(input string tag, input int last);
    logic [15:0] sum = '0;
    logic [15:0] e;
    int          n;
    chk({tag, "_result_count"}, got_addr.size(), last + 1);
    chk({tag, "_accept_count"}, acc_addr.size(), last + 1);
    n = (got_addr.size() < last + 1) ? got_addr.size() : last + 1;
    for (int i = 0; i <= last; i++) begin
      e = fpu_fn(m_op[i], m_a[i], m_b[i]);
      sum = sum + e;
      if (i < n) begin
        chk($sformatf("%s_res_addr[%0d]", tag, i), got_addr[i], i);
        chk($sformatf("%s_res_data[%0d]", tag, i), 32'(got_data[i]), 32'(e));
      end
      if (i < acc_addr.size()) chk($sformatf("%s_req_addr[%0d]", tag, i), acc_addr[i], i);
    end
    chk({tag, "_checksum"}, 32'(checksum), 32'(sum));
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int ac0;
    int n0;
    int last;

    reset = 1'b1;
    start = 1'b0;
    cfg_last = '0;
    fpu_req_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      m_op[i] = 2'($urandom_range(0, 3));
      m_a[i]  = 16'($urandom);
      m_b[i]  = 16'($urandom);
    end

    // Reset state
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Four back-to-back requests, latency 2
    lat = 2;
    start_run(3);
    wait_done("basic", 1'b0, 200);
    check_results("basic", 3);
    if (acc_cyc.size() == 4) chk("basic_back_to_back", acc_cyc[3] - acc_cyc[0], 3);
    chk("basic_req_valid_done", 32'(fpu_req_valid), 0);

    // Ready stall: valid and payload hold, nothing pushed
    fpu_req_ready = 1'b0;
    start_run(7);
    ac0 = accept_cnt;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(fpu_req_valid), 1);
      chk("stall_mem_addr", 32'(mem_addr), 0);
      chk("stall_op", 32'(fpu_op), 32'(m_op[0]));
      chk("stall_opA", 32'(fpu_opA), 32'(m_a[0]));
      chk("stall_opB", 32'(fpu_opB), 32'(m_b[0]));
      @(negedge clock);
    end
    chk("stall_no_accept", accept_cnt - ac0, 0);
    fpu_req_ready = 1'b1;
    wait_done("stall", 1'b0, 200);
    check_results("stall", 7);

    // Outstanding limit with responses held
    auto_rsp = 1'b0;
    lat = 1;
    ac0 = accept_cnt;
    start_run(9);
    repeat (10) @(negedge clock);
    chk("limit_accepts", accept_cnt - ac0, 4);
    chk("limit_valid_low", 32'(fpu_req_valid), 0);
    release_n = 1;
    repeat (4) @(negedge clock);
    chk("limit_one_more", accept_cnt - ac0, 5);
    chk("limit_valid_low2", 32'(fpu_req_valid), 0);
    auto_rsp = 1'b1;
    wait_done("limit", 1'b0, 200);
    check_results("limit", 9);

    // Full 256-entry run with random ready, pointer wrap
    lat = $urandom_range(1, 4);
    start_run(255);
    wait_done("wrap", 1'b1, 4000);
    check_results("wrap", 255);
    if (got_addr.size() > 0) chk("wrap_final_addr", got_addr[got_addr.size()-1], 255);
    chk("wrap_issue_ptr", 32'(mem_addr), 0);

    // Random runs
    for (int r = 0; r < 3; r++) begin
      last = $urandom_range(0, 40);
      lat  = $urandom_range(1, 5);
      start_run(last);
      wait_done($sformatf("rand%0d", r), 1'b1, 1000);
      check_results($sformatf("rand%0d", r), last);
    end

    // Spurious response in IDLE
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n0 = got_addr.size();
    @(negedge clock);
    spur = 1'b1;
    @(negedge clock);
    spur = 1'b0;
    chk("spur_err", 32'(err), 1);
    repeat (2) @(negedge clock);
    chk("spur_err_sticky", 32'(err), 1);
    chk("spur_no_result", got_addr.size() - n0, 0);
    chk("spur_checksum", 32'(checksum), 0);
    chk("spur_idle", 32'(busy), 0);
    lat = 2;
    start_run(2);
    chk("spur_err_cleared", 32'(err), 0);
    wait_done("post_spur", 1'b0, 200);
    check_results("post_spur", 2);
    chk("post_spur_err", 32'(err), 0);

    // Asynchronous reset with three requests outstanding
    auto_rsp = 1'b0;
    ac0 = accept_cnt;
    start_run(20);
    for (int k = 0; k < 50 && (accept_cnt - ac0) < 3; k++) @(negedge clock);
    fpu_req_ready = 1'b0;
    chk("midrst_outstanding", accept_cnt - ac0, 3);
    chk("midrst_busy", 32'(busy), 1);
    n0 = got_addr.size();
    #2;
    reset = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clock);
    reset = 1'b0;
    fpu_req_ready = 1'b1;
    auto_rsp = 1'b1;
    repeat (6) @(negedge clock);
    chk("midrst_late_err", 32'(err), 1);
    chk("midrst_no_result", got_addr.size() - n0, 0);
    chk("midrst_rsp_drained", pend.size(), 0);
    chk("midrst_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/fpu_test_seq.md
FPU_TEST_SEQ -- requirements
Module: fpu_test_seq

Interface
REQ-001 Parameter MAX_OUTST, default 4, SHALL set the maximum in-flight FPU requests (power of two, 2..16).
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 start  input  1  SHALL be a one-cycle pulse that begins a run; ignored unless state is IDLE or DONE.
REQ-005 cfg_last  input  8  SHALL be the last operand-memory address of the run, sampled on accepted start.
REQ-006 mem_addr  output  8  SHALL be the address to the operand memory, which returns data combinationally.
REQ-007 mem_op/mem_opA/mem_opB  input  2/16/16  SHALL be the op code and operands read at mem_addr.
REQ-008 fpu_req_valid  output  1  SHALL mark a request to the FPU.
REQ-009 fpu_req_ready  input  1  SHALL be FPU acceptance; transfer when valid && ready.
REQ-010 fpu_op/fpu_opA/fpu_opB  output  2/16/16  SHALL be the request payload.
REQ-011 fpu_rsp_valid/fpu_rsp_data  input  1/16  SHALL be FPU results, returned in request order, no backpressure.
REQ-012 res_valid/res_addr/res_data  output  1/8/16  SHALL be the tagged result stream.
REQ-013 busy, done, err  output  1 each  SHALL report run status and a sticky protocol error.
REQ-014 checksum  output  16  SHALL be the running sum of results.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE/DONE --accepted start--> ISSUE; issue_ptr<=0, checksum<=0, err<=0, cfg_last latched.
REQ-017 mem_addr SHALL equal issue_ptr in every state; payload outputs SHALL pass mem_op/opA/opB through combinationally.
REQ-018 fpu_req_valid SHALL be 1 only in ISSUE with outstanding < MAX_OUTST; once asserted, valid and payload SHALL hold until accepted.
REQ-019 On acceptance, issue_ptr SHALL be pushed into the in-order tag FIFO, outstanding++, issue_ptr++ (8-bit wrap).
REQ-020 Acceptance with issue_ptr == cfg_last SHALL move ISSUE->DRAIN; cfg_last=255 issues 256 requests, pointer wraps to 0.
REQ-021 On fpu_rsp_valid with FIFO non-empty: pop tag, outstanding--, and next cycle res_valid=1, res_addr=tag, res_data=fpu_rsp_data (1-cycle latency); checksum += data mod 2^16 in that same next cycle.
REQ-022 Simultaneous acceptance and response SHALL leave outstanding unchanged; push and pop both occur.
REQ-023 fpu_rsp_valid with FIFO empty SHALL set err (sticky until next start), produce no res_valid, leave checksum unchanged.
REQ-024 DRAIN->DONE when outstanding==0 and no response this cycle; done=1 in DONE only; busy=1 in ISSUE and DRAIN.
REQ-025 start while busy SHALL be ignored with no state change.
REQ-026 Results SHALL continue to be accepted in DRAIN; no requests issued in DRAIN or DONE.

Reset
REQ-027 Reset SHALL force IDLE, issue_ptr=0, outstanding=0, FIFO empty, cfg_last=0.
REQ-028 Reset SHALL force all outputs to 0: fpu_req_valid, res_valid, res_addr, res_data, busy, done, err, checksum.
REQ-029 Reset mid-run SHALL discard in-flight tags; responses arriving afterwards in IDLE SHALL set err.

Structure
REQ-030 Package fpu_test_pkg SHALL hold the state enum, OP_W=2, DATA_W=16, ADDR_W=8.
REQ-031 The tag storage SHALL be a sub-module tag_fifo (depth MAX_OUTST, width ADDR_W, synchronous push/pop, async reset).

Verification
REQ-032 cfg_last=3, ready=1, FPU latency 2 -> four requests addr 0..3 back-to-back, res_addr 0,1,2,3, done after last result, checksum=sum mod 2^16.
REQ-033 ready=0 for 5 cycles with valid up -> payload stable, mem_addr stable, no push; issue resumes on ready.
REQ-034 MAX_OUTST=4, FPU holds responses -> exactly 4 accepts, valid drops; one response -> one more accept same cycle allowed.
REQ-035 cfg_last=255 -> 256 results, final res_addr=255, issue_ptr wraps to 0.
REQ-036 Spurious fpu_rsp_valid in IDLE -> err=1, no res_valid; next start clears err.
REQ-037 Reset asserted in ISSUE with 3 outstanding -> all outputs 0 asynchronously, state IDLE.
